// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] Data1,
    input  logic [31:0] Data2,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Div_By_Zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [4:0]  cnt;
    logic        prod_neg;
    logic        rem_neg;
    logic        zero_div;

    logic        in_signed;
    logic        in_div;
    logic        in_zero;
    logic [31:0] d1_abs;
    logic [31:0] d2_abs;
    logic        accept;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ok;

    logic        fix_signed;
    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    assign in_signed = ~Op[0];
    assign in_div    = Op[1];
    assign in_zero   = in_div && (Data2 == 32'd0);
    assign d1_abs    = (in_signed && Data1[31]) ? -Data1 : Data1;
    assign d2_abs    = (in_signed && Data2[31]) ? -Data2 : Data2;
    assign accept    = Start && ((state == S_IDLE) || (state == S_DONE));

    // Multiply: multiplier sits in acc[31:0] and shifts out LSB-first while the
    // partial product grows down from acc[63:32].
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

    // Divide: dividend shifts out of acc[31:0] MSB-first, quotient bits shift in.
    assign div_shift = {rem, acc[31]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_diff[32];

    assign fix_signed = ~op_q[0] && ~zero_div;
    assign mul_res    = (fix_signed && prod_neg) ? -acc : acc;
    assign quo_res    = (fix_signed && prod_neg) ? -acc[31:0] : acc[31:0];
    assign rem_res    = (fix_signed && rem_neg) ? -rem : rem;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            op_q        <= 2'd0;
            opnd        <= 32'd0;
            acc         <= 64'd0;
            rem         <= 32'd0;
            cnt         <= 5'd0;
            prod_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            zero_div    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
            Div_By_Zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    Done <= 1'b0;
                    if (accept) begin
                        op_q     <= Op;
                        opnd     <= in_div ? d2_abs : d1_abs;
                        // A zero divisor keeps the raw dividend so it falls out
                        // of the iterations unchanged as the remainder.
                        acc      <= in_div ? {32'd0, (in_zero ? Data1 : d1_abs)}
                                           : {32'd0, d2_abs};
                        rem      <= 32'd0;
                        prod_neg <= Data1[31] ^ Data2[31];
                        rem_neg  <= Data1[31];
                        zero_div <= in_zero;
                        cnt      <= 5'd0;
                        Busy     <= 1'b1;
                        state    <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_q[1]) begin
                        rem       <= div_ok ? div_diff[31:0] : div_shift[31:0];
                        acc[31:0] <= {acc[30:0], div_ok};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (op_q[1]) begin
                        HI          <= rem_res;
                        LO          <= quo_res;
                        Div_By_Zero <= zero_div;
                    end else begin
                        HI          <= mul_res[63:32];
                        LO          <= mul_res[31:0];
                        Div_By_Zero <= 1'b0;
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
